pam_dfe_lanes: RTL and testbench

Parametrised multi-lane PAM5 decision-feedback slicer: it is the configurable successor to the fixed 4-lane, 14-tap PDFD datapath. Each of LANES receive lanes subtracts post-cursor ISI from its sample, computed from that lane's own decision history and a per-lane tap bank, then slices the result to a PAM5 symbol. The block adds three things: a double-buffered tap bank, bypass and training modes, and a per-lane slicer-error output for the adaptation loop. It sits between the ADC/FFE front end and the symbol deframer.

---
 rtl/pam_dfe_lanes_if.sv | 28 ++
 rtl/pam_dfe_lanes.sv | 174 +++++++++++++++++
 tb/tb_pam_dfe_lanes.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/pam_dfe_lanes_if.sv
// Receive-side bus of the multi-lane PAM5 DFE slicer: samples, taps and
// controls in; decided symbols and slicer errors out.
interface pam_dfe_lanes_if #(
    parameter int LANES = 4,
    parameter int TAPS  = 14,
    parameter int DW    = 8,
    parameter int TW    = 8
);
    logic                        inValid;
    logic [LANES*DW-1:0]         rxSamples;
    logic [LANES*TAPS*TW-1:0]    taps;
    logic                        tapLoad;
    logic [1:0]                  mode;
    logic [LANES*3-1:0]          refSymbols;
    logic                        flush;
    logic                        outValid;
    logic [LANES*3-1:0]          rxSymbols;
    logic [LANES*(DW+2)-1:0]     err;

    modport master (
        output inValid, rxSamples, taps, tapLoad, mode, refSymbols, flush,
        input  outValid, rxSymbols, err
    );
    modport slave (
        input  inValid, rxSamples, taps, tapLoad, mode, refSymbols, flush,
        output outValid, rxSymbols, err
    );
endinterface

// File: rtl/pam_dfe_lanes.sv
// Multi-lane PAM5 decision-feedback slicer: S1 input register, S2 per-lane
// ISI cancel + slice + error, with a 1-cycle decision feedback recursion.
module pam_dfe_lane #(
    parameter int TAPS      = 14,
    parameter int DW        = 8,
    parameter int TW        = 8,
    parameter int TAP_SHIFT = 7,
    parameter int L_N2      = -103,
    parameter int L_N1      = -52,
    parameter int L_P1      = 51,
    parameter int L_P2      = 101
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 vld_i,
    input  logic                 flush_i,
    input  logic [1:0]           mode_i,
    input  logic signed [DW-1:0] smp_i,
    input  logic [2:0]           ref_i,
    input  logic [TAPS*TW-1:0]   taps_i,
    output logic [2:0]           sym_o,
    output logic [DW+1:0]        err_o
);
    localparam int EW  = DW + 2;
    localparam int ISW = TW + DW + $clog2(TAPS);

    localparam logic signed [EW-1:0] LV_N2 = EW'(L_N2);
    localparam logic signed [EW-1:0] LV_N1 = EW'(L_N1);
    localparam logic signed [EW-1:0] LV_P1 = EW'(L_P1);
    localparam logic signed [EW-1:0] LV_P2 = EW'(L_P2);
    // Floor midpoints; >>> on int floors negative sums, so ties go upward.
    localparam logic signed [EW-1:0] TH_P2 = EW'((L_P1 + L_P2) >>> 1);
    localparam logic signed [EW-1:0] TH_P1 = EW'(L_P1 >>> 1);
    localparam logic signed [EW-1:0] TH_Z  = EW'(L_N1 >>> 1);
    localparam logic signed [EW-1:0] TH_N1 = EW'((L_N1 + L_N2) >>> 1);

    localparam logic signed [ISW:0] EQ_MAX = (ISW+1)'(2**(DW+1) - 1);
    localparam logic signed [ISW:0] EQ_MIN = (ISW+1)'(-(2**(DW+1)));
    localparam logic signed [EW:0]  ER_MAX = (EW+1)'(2**(DW+1) - 1);
    localparam logic signed [EW:0]  ER_MIN = (EW+1)'(-(2**(DW+1)));

    function automatic logic signed [EW-1:0] lvl(input logic [2:0] s);
        case (s)
            3'b010:  return LV_P2;
            3'b001:  return LV_P1;
            3'b111:  return LV_N1;
            3'b110:  return LV_N2;
            default: return '0;
        endcase
    endfunction

    logic [TAPS-1:0][2:0]   h_q, h_d;
    logic [2:0]             sym_q;
    logic signed [EW-1:0]   err_q;

    logic signed [ISW-1:0]  isi, isi_s;
    logic signed [ISW:0]    eq_full;
    logic signed [EW-1:0]   eq, err_d;
    logic signed [EW:0]     err_full;
    logic [2:0]             sym_d, ref_c, h_in;

    always_comb begin
        isi = '0;
        for (int k = 0; k < TAPS; k++)
            isi = isi + ISW'($signed(taps_i[(TAPS-1-k)*TW +: TW])) * ISW'(lvl(h_q[k]));
        isi_s = isi >>> TAP_SHIFT;

        eq_full = (mode_i == 2'd1) ? (ISW+1)'(smp_i)
                                   : (ISW+1)'(smp_i) - (ISW+1)'(isi_s);
        eq = (eq_full > EQ_MAX) ? EW'(EQ_MAX) :
             (eq_full < EQ_MIN) ? EW'(EQ_MIN) : eq_full[EW-1:0];

        if      (eq >= TH_P2) sym_d = 3'b010;
        else if (eq >= TH_P1) sym_d = 3'b001;
        else if (eq >= TH_Z)  sym_d = 3'b000;
        else if (eq >= TH_N1) sym_d = 3'b111;
        else                  sym_d = 3'b110;

        err_full = (EW+1)'(eq) - (EW+1)'(lvl(sym_d));
        err_d = (err_full > ER_MAX) ? EW'(ER_MAX) :
                (err_full < ER_MIN) ? EW'(ER_MIN) : err_full[EW-1:0];

        // Codes +3 and -3/-4 carry no PAM5 level and enter the history as 0.
        case (ref_i)
            3'b000, 3'b001, 3'b010, 3'b110, 3'b111: ref_c = ref_i;
            default:                                ref_c = 3'b000;
        endcase
        h_in = (mode_i == 2'd2) ? ref_c : sym_d;

        h_d = h_q;
        if (flush_i)    h_d = '0;
        else if (vld_i) h_d = {h_q[TAPS-2:0], h_in};
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            h_q   <= '0;
            sym_q <= '0;
            err_q <= '0;
        end else begin
            h_q <= h_d;
            if (vld_i) begin
                sym_q <= sym_d;
                err_q <= err_d;
            end
        end
    end

    assign sym_o = sym_q;
    assign err_o = err_q;
endmodule

module pam_dfe_lanes #(
    parameter int LANES     = 4,
    parameter int TAPS      = 14,
    parameter int DW        = 8,
    parameter int TW        = 8,
    parameter int TAP_SHIFT = 7,
    parameter int L_N2      = -103,
    parameter int L_N1      = -52,
    parameter int L_P1      = 51,
    parameter int L_P2      = 101
) (
    input  logic           clock,
    input  logic           reset_n,
    pam_dfe_lanes_if.slave io
);
    localparam int EW = DW + 2;

    // [0] = S1 holds a vector, [1] = outputs valid
    logic [1:0]                vld_pipe_q;
    logic [LANES*DW-1:0]       smp_q;
    logic [LANES*3-1:0]        ref_q;
    logic [1:0]                mode_q;
    logic [LANES*TAPS*TW-1:0]  tap_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            vld_pipe_q <= '0;
            smp_q      <= '0;
            ref_q      <= '0;
            mode_q     <= '0;
            tap_q      <= '0;
        end else begin
            vld_pipe_q <= {vld_pipe_q[0], io.inValid};
            if (io.inValid) begin
                smp_q  <= io.rxSamples;
                ref_q  <= io.refSymbols;
                mode_q <= io.mode;
            end
            if (io.tapLoad) tap_q <= io.taps;
        end
    end

    assign io.outValid = vld_pipe_q[1];

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        pam_dfe_lane #(
            .TAPS(TAPS), .DW(DW), .TW(TW), .TAP_SHIFT(TAP_SHIFT),
            .L_N2(L_N2), .L_N1(L_N1), .L_P1(L_P1), .L_P2(L_P2)
        ) u_lane (
            .clk_i   (clock),
            .rst_ni  (reset_n),
            .vld_i   (vld_pipe_q[0]),
            .flush_i (io.flush),
            .mode_i  (mode_q),
            .smp_i   (smp_q[(LANES-1-l)*DW +: DW]),
            .ref_i   (ref_q[(LANES-1-l)*3 +: 3]),
            .taps_i  (tap_q[(LANES-1-l)*TAPS*TW +: TAPS*TW]),
            .sym_o   (io.rxSymbols[(LANES-1-l)*3 +: 3]),
            .err_o   (io.err[(LANES-1-l)*EW +: EW])
        );
    end
endmodule

// File: tb/tb_pam_dfe_lanes.sv
// Scoreboard bench for pam_dfe_lanes: expected symbols/errors are queued as
// vectors are driven and compared when io.outValid presents them.
module tb_pam_dfe_lanes;
    localparam int LANES = 4, TAPS = 14, DW = 8, TW = 8, EW = DW + 2;

    typedef struct packed {
        logic [LANES*3-1:0]  sym;
        logic [LANES*EW-1:0] err;
    } exp_t;

    logic clock = 1'b0;
    logic reset_n = 1'b1;
    always #5 clock = ~clock;

    pam_dfe_lanes_if #(.LANES(LANES), .TAPS(TAPS), .DW(DW), .TW(TW)) io ();

    pam_dfe_lanes #(.LANES(LANES), .TAPS(TAPS), .DW(DW), .TW(TW)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .io      (io)
    );

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_out = 0;

    int sq[5] = '{101, -52, 0, 30, -80};
    int ss[5] = '{2, -1, 0, 1, -2};
    int se[5] = '{0, 0, 0, -21, 23};

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [LANES*DW-1:0] v4(input int a, input int b, input int c, input int d);
        return {8'(a), 8'(b), 8'(c), 8'(d)};
    endfunction
    function automatic logic [LANES*3-1:0] s4(input int a, input int b, input int c, input int d);
        return {3'(a), 3'(b), 3'(c), 3'(d)};
    endfunction
    function automatic logic [LANES*EW-1:0] e4(input int a, input int b, input int c, input int d);
        return {10'(a), 10'(b), 10'(c), 10'(d)};
    endfunction
    function automatic logic [LANES*TAPS*TW-1:0] taps_all(input int t1, input int tr);
        logic [LANES*TAPS*TW-1:0] t = '0;
        for (int l = 0; l < LANES; l++)
            for (int k = 0; k < TAPS; k++)
                t[(LANES*TAPS-1-(l*TAPS+k))*TW +: TW] = TW'((k == 0) ? t1 : tr);
        return t;
    endfunction

    task automatic send(input logic [LANES*DW-1:0] smp, input logic [LANES*3-1:0] rs,
                        input logic [1:0] md, input logic fl,
                        input logic [LANES*3-1:0] es, input logic [LANES*EW-1:0] ee);
        io.inValid    = 1'b1;
        io.rxSamples  = smp;
        io.refSymbols = rs;
        io.mode       = md;
        io.flush      = fl;
        sb_q.push_back('{sym: es, err: ee});
        @(negedge clock);
        io.inValid = 1'b0;
        io.flush   = 1'b0;
    endtask

    task automatic load(input logic [LANES*TAPS*TW-1:0] t);
        io.taps    = t;
        io.tapLoad = 1'b1;
        @(negedge clock);
        io.tapLoad = 1'b0;
    endtask

    task automatic flush_cyc();
        io.flush = 1'b1;
        @(negedge clock);
        io.flush = 1'b0;
    endtask

    always @(negedge clock) begin
        exp_t e;
        if (reset_n && io.outValid) begin
            chk($sformatf("sb_avail%0d", n_out), 64'(sb_q.size() != 0), 64'(1));
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                chk($sformatf("sym%0d", n_out), 64'(io.rxSymbols), 64'(e.sym));
                chk($sformatf("err%0d", n_out), 64'(io.err), 64'(e.err));
            end
            n_out++;
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: run did not finish, %0d compared", n_cmp);
        $fatal(1);
    end

    initial begin
        io.inValid = 1'b0; io.rxSamples = '0; io.taps = '0; io.tapLoad = 1'b0;
        io.mode = 2'd0; io.refSymbols = '0; io.flush = 1'b0;
        #1 reset_n = 1'b0;
        #2;
        chk("rst_vld", 64'(io.outValid), 64'(0));
        chk("rst_sym", 64'(io.rxSymbols), 64'(0));
        chk("rst_err", 64'(io.err), 64'(0));
        @(negedge clock);
        reset_n = 1'b1;

        // Zero taps: lanes get rotated copies of the same sequence.
        for (int i = 0; i < 5; i++) begin
            send(v4(sq[i%5], sq[(i+1)%5], sq[(i+2)%5], sq[(i+3)%5]), '0, 2'd0, 1'b0,
                 s4(ss[i%5], ss[(i+1)%5], ss[(i+2)%5], ss[(i+3)%5]),
                 e4(se[i%5], se[(i+1)%5], se[(i+2)%5], se[(i+3)%5]));
            if (i == 0) chk("lat_n", 64'(io.outValid), 64'(0));
            if (i == 1) chk("lat_n1", 64'(io.outValid), 64'(1));
        end
        send(v4(76, 75, -78, -79), '0, 2'd0, 1'b0, s4(2, 1, -1, -2), e4(-25, 24, -26, 24));

        // Single tap, back-to-back then with bubbles.
        load(taps_all(64, 0));
        flush_cyc();
        send(v4(101, 101, 101, 101), '0, 2'd0, 1'b0, s4(2, 2, 2, 2), e4(0, 0, 0, 0));
        send(v4(76, 76, 76, 76), '0, 2'd0, 1'b0, s4(1, 1, 1, 1), e4(-25, -25, -25, -25));
        flush_cyc();
        send(v4(101, 101, 101, 101), '0, 2'd0, 1'b0, s4(2, 2, 2, 2), e4(0, 0, 0, 0));
        repeat (3) @(negedge clock);
        chk("bub_vld", 64'(io.outValid), 64'(0));
        chk("bub_hold", 64'(io.rxSymbols), 64'(s4(2, 2, 2, 2)));
        send(v4(76, 76, 76, 76), '0, 2'd0, 1'b0, s4(1, 1, 1, 1), e4(-25, -25, -25, -25));

        // Training vs DFE, then reserved ref codes and mode 3.
        flush_cyc();
        send(v4(0, 0, 0, 0), s4(-2, -2, -2, -2), 2'd2, 1'b0, s4(0, 0, 0, 0), e4(0, 0, 0, 0));
        send(v4(-30, -30, -30, -30), '0, 2'd2, 1'b0, s4(0, 0, 0, 0), e4(22, 22, 22, 22));
        flush_cyc();
        send(v4(0, 0, 0, 0), s4(-2, -2, -2, -2), 2'd0, 1'b0, s4(0, 0, 0, 0), e4(0, 0, 0, 0));
        send(v4(-30, -30, -30, -30), '0, 2'd0, 1'b0, s4(-1, -1, -1, -1), e4(22, 22, 22, 22));
        flush_cyc();
        send(v4(0, 0, 0, 0), s4(3, -4, 3, -4), 2'd2, 1'b0, s4(0, 0, 0, 0), e4(0, 0, 0, 0));
        send(v4(-30, -30, -30, -30), '0, 2'd3, 1'b0, s4(-1, -1, -1, -1), e4(22, 22, 22, 22));

        // Tap load on the same edge as a sample, then flush alongside valid.
        load(taps_all(0, 0));
        flush_cyc();
        send(v4(101, 101, 101, 101), '0, 2'd0, 1'b0, s4(2, 2, 2, 2), e4(0, 0, 0, 0));
        io.taps = taps_all(64, 0);
        io.tapLoad = 1'b1;
        send(v4(76, 76, 76, 76), '0, 2'd0, 1'b0, s4(1, 1, 1, 1), e4(-25, -25, -25, -25));
        io.tapLoad = 1'b0;
        send(v4(76, 76, 76, 76), '0, 2'd0, 1'b1, s4(2, 2, 2, 2), e4(-25, -25, -25, -25));
        send(v4(76, 76, 76, 76), '0, 2'd0, 1'b0, s4(1, 1, 1, 1), e4(-25, -25, -25, -25));

        // Saturation with full-scale taps, then bypass with history shift.
        load(taps_all(127, 127));
        repeat (14) send(v4(101, 101, 101, 101), '0, 2'd1, 1'b0, s4(2, 2, 2, 2), e4(0, 0, 0, 0));
        send(v4(-128, -128, -128, -128), '0, 2'd0, 1'b0, s4(-2, -2, -2, -2),
             e4(-409, -409, -409, -409));
        repeat (14) send(v4(101, 101, 101, 101), '0, 2'd1, 1'b0, s4(2, 2, 2, 2), e4(0, 0, 0, 0));
        send(v4(-128, -128, -128, -128), '0, 2'd1, 1'b0, s4(-2, -2, -2, -2),
             e4(-25, -25, -25, -25));
        load(taps_all(64, 0));
        send(v4(0, 0, 0, 0), '0, 2'd0, 1'b0, s4(1, 1, 1, 1), e4(1, 1, 1, 1));

        // Reset in the middle of valid traffic.
        send(v4(101, 101, 101, 101), '0, 2'd1, 1'b0, s4(2, 2, 2, 2), e4(0, 0, 0, 0));
        send(v4(101, 101, 101, 101), '0, 2'd1, 1'b0, s4(2, 2, 2, 2), e4(0, 0, 0, 0));
        io.inValid = 1'b1;
        #2 reset_n = 1'b0;
        #1;
        chk("rst2_vld", 64'(io.outValid), 64'(0));
        chk("rst2_sym", 64'(io.rxSymbols), 64'(0));
        chk("rst2_err", 64'(io.err), 64'(0));
        sb_q.delete();
        io.inValid = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        send(v4(101, 101, 101, 101), '0, 2'd0, 1'b0, s4(2, 2, 2, 2), e4(0, 0, 0, 0));
        send(v4(76, 76, 76, 76), '0, 2'd0, 1'b0, s4(2, 2, 2, 2), e4(-25, -25, -25, -25));

        repeat (4) @(negedge clock);
        chk("drain", 64'(sb_q.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
